// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed/unsigned multiplier and restoring divider
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_zero
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t             state_q;
  logic               op_q, sgn_q, neg_q, nega_q, dz_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   abs_a, abs_b, hi_fix, lo_fix;
  logic [WIDTH:0]     add_d, rem_sh, sub_d;
  logic [2*WIDTH-1:0] step_d, fix_d;
  assign busy     = busy_q;
  assign done     = done_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign div_zero = div_zero_q;
  assign abs_a = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
  // One shift-add (multiply) or restoring shift-subtract (divide) step, plus the sign fix-up
  always_comb begin
    add_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    sub_d  = rem_sh - {1'b0, b_q};
    step_d = !op_q   ? {add_d, acc_q[WIDTH-1:1]} :
             sub_d[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                            {sub_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    lo_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    hi_fix = nega_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_d  = !op_q ? (neg_q ? -acc_q : acc_q) : {hi_fix, lo_fix};
  end
  // Sequencer with registered outputs; results land on HI/LO only in the DONE cycle
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      sgn_q      <= 1'b0;
      neg_q      <= 1'b0;
      nega_q     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q       <= op;
          sgn_q      <= is_signed;
          a_q        <= a;
          b_q        <= b;
          busy_q     <= 1'b1;
          div_zero_q <= 1'b0;
          dz_q       <= op && (b == '0);
          acc_q      <= {a, {WIDTH{1'b1}}};
          state_q    <= (op && (b == '0)) ? DONE : PREP;
        end
        PREP: begin
          acc_q   <= {{WIDTH{1'b0}}, abs_a};
          b_q     <= abs_b;
          neg_q   <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          nega_q  <= sgn_q & a_q[WIDTH-1];
          cnt_q   <= CNT_W'(WIDTH - 1);
          state_q <= RUN;
        end
        RUN: begin
          acc_q   <= step_d;
          cnt_q   <= (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
          state_q <= (cnt_q == '0) ? FIX : RUN;
        end
        FIX: begin
          acc_q   <= fix_d;
          state_q <= DONE;
        end
        DONE: begin
          hi_q       <= acc_q[2*WIDTH-1:WIDTH];
          lo_q       <= acc_q[WIDTH-1:0];
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq results, latency, reset and start handling
module tb_muldiv_seq;
  logic        Clock = 1'b0;
  logic        Resetn, start, op, is_signed;
  logic [31:0] a, b, HI, LO;
  logic        busy, done, div_zero;
  int          n_chk = 0, n_fail = 0, lat, seen;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .HI(HI), .LO(LO), .div_zero(div_zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request; optionally re-pulse start (divide 100/7) rp cycles after acceptance
  task automatic do_op(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y,
                       input int rp, output int l);
    @(negedge Clock);
    op = o; is_signed = s; a = x; b = y; start = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    l = 0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    while (!done && l < 100) begin
      if (l == rp) begin
        start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
      end else start = 1'b0;
      @(posedge Clock);
      #1 l++;
    end
    start = 1'b0;
    check("busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge Clock);
    #1 check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    Resetn = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    #14 Resetn = 1'b1;

    do_op(1'b0, 1'b0, 32'h22, 32'h24, -1, lat);
    check("umul_lat", lat, 35);
    check("umul_res", {HI, LO}, 64'h00000000_000004C8);

    do_op(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, -1, lat);
    check("smul_res", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);

    do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat);
    check("umul_max", {HI, LO}, 64'hFFFFFFFE_00000001);

    do_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, -1, lat);
    check("sdiv_lat", lat, 35);
    check("sdiv_res", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

    do_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, lat);
    check("sdiv_ovf", {HI, LO}, 64'h00000000_80000000);
    check("sdiv_ovf_dz", {63'd0, div_zero}, 64'd0);

    do_op(1'b1, 1'b0, 32'd1000, 32'd3, -1, lat);
    check("udiv_res", {HI, LO}, 64'h00000001_0000014D);

    do_op(1'b1, 1'b0, 32'h1234, 32'd0, -1, lat);
    check("dz_lat", lat, 1);
    check("dz_flag", {63'd0, div_zero}, 64'd1);
    check("dz_res", {HI, LO}, 64'h00001234_FFFFFFFF);

    do_op(1'b1, 1'b1, 32'hFFFFFFF0, 32'd0, -1, lat);
    check("sdz_res", {HI, LO}, 64'hFFFFFFF0_FFFFFFFF);
    check("sdz_flag", {63'd0, div_zero}, 64'd1);

    // Next multiply clears the flag on acceptance while HI/LO hold the old result
    @(negedge Clock);
    op = 1'b0; is_signed = 1'b0; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    check("dz_cleared", {63'd0, div_zero}, 64'd0);
    repeat (10) @(posedge Clock);
    #1 check("hold_busy", {HI, LO}, 64'hFFFFFFF0_FFFFFFFF);
    seen = 0;
    while (!done && seen < 100) begin
      @(posedge Clock);
      #1 seen++;
    end
    check("mul_after_dz", {HI, LO}, 64'd35);

    do_op(1'b0, 1'b0, 32'd3, 32'd4, 5, lat);
    check("repulse_lat", lat, 35);
    check("repulse_res", {HI, LO}, 64'd12);
    repeat (3) @(posedge Clock);
    #1 check("repulse_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of RUN abandons the operation
    @(negedge Clock);
    op = 1'b0; is_signed = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    repeat (11) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_res", {HI, LO}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge Clock);
      #1 if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_hold", {HI, LO}, 64'd0);

    do_op(1'b1, 1'b0, 32'd100, 32'd7, -1, lat);
    check("post_rst_lat", lat, 35);
    check("post_rst_res", {HI, LO}, 64'h00000002_0000000E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
